// File: rtl/traffic_pkg.sv
// traffic_pkg
//   Shared types for the intersection controller family.
//   - ctrl_state_e : controller FSM states
//   - lamp_e       : per-phase lamp encoding (exactly one lamp lit per phase)
//   - phase_width  : width of a phase index, at least 1 bit
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2,
    ST_PREEMPT = 2'd3
  } ctrl_state_e;

  typedef enum logic [1:0] {
    LAMP_RED    = 2'd0,
    LAMP_YELLOW = 2'd1,
    LAMP_GREEN  = 2'd2
  } lamp_e;

  function automatic int phase_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/intersection_controller_phase_timer.sv
// phase_timer
//   Interval down-counter. Loading takes priority; otherwise the count
//   decrements and parks at zero. done_o flags count == 0, so an interval
//   loaded with DUR-1 lasts exactly DUR cycles.
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset (count <= RST_VAL)
//   load_i      : load strobe
//   load_val_i  : value loaded on load_i
//   done_o      : count is zero
module phase_timer
  import traffic_pkg::*;
#(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RST_VAL;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/intersection_controller.sv
// intersection_controller
//   Round-robin multi-phase intersection controller: GREEN -> YELLOW ->
//   ALL_RED per phase, latched pedestrian requests served with a timed WALK
//   at the start of the phase's green, and emergency preemption onto a
//   selected phase.
// Ports
//   clk, rst_n             : clock, asynchronous active-low reset
//   pedestrian_request     : per-phase level request (latched)
//   emergency              : preemption request (level)
//   emergency_phase        : phase served on preemption
//   traffic_red/yellow/green : per-phase lamps, exactly one lit per phase
//   pedestrian_walk/dont_walk: per-phase walk indication, dont_walk = ~walk
//   active_phase           : phase owning (or last owning) green/yellow
//   preempt_active         : high while in PREEMPT
//   state_o                : FSM state, for debug/observation
// Handshake: none; all inputs are sampled levels, all outputs are decodes of
//   registered state only (no input-to-output combinational path).
module intersection_controller
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES     = 4,
  parameter int GREEN_CYCLES   = 16,
  parameter int YELLOW_CYCLES  = 4,
  parameter int ALL_RED_CYCLES = 2,
  parameter int WALK_CYCLES    = 8,
  parameter int CNT_W          = 8,
  localparam int PH_W          = phase_width(NUM_PHASES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_PHASES-1:0] pedestrian_request,
  input  logic                  emergency,
  input  logic [PH_W-1:0]       emergency_phase,
  output logic [NUM_PHASES-1:0] traffic_red,
  output logic [NUM_PHASES-1:0] traffic_yellow,
  output logic [NUM_PHASES-1:0] traffic_green,
  output logic [NUM_PHASES-1:0] pedestrian_walk,
  output logic [NUM_PHASES-1:0] pedestrian_dont_walk,
  output logic [PH_W-1:0]       active_phase,
  output logic                  preempt_active,
  output ctrl_state_e           state_o
);

  ctrl_state_e           state_q, state_d;
  logic [PH_W-1:0]       active_q, active_d;
  logic                  started_q, started_d;
  logic [NUM_PHASES-1:0] req_q, req_d;
  logic                  walk_q, walk_d;
  logic [CNT_W-1:0]      walk_cnt_q, walk_cnt_d;

  logic                  tmr_load;
  logic [CNT_W-1:0]      tmr_load_val;
  logic                  tmr_done;
  logic [PH_W-1:0]       next_phase;
  logic [NUM_PHASES-1:0] active_oh;
  lamp_e                 lamp [NUM_PHASES];

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (CNT_W'(ALL_RED_CYCLES - 1))
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .done_o     (tmr_done)
  );

  // The very first green after reset goes to phase 0 without incrementing.
  assign next_phase = !started_q                            ? '0 :
                      (active_q == PH_W'(NUM_PHASES - 1))   ? '0 :
                                                              active_q + PH_W'(1);

  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    started_d    = started_q;
    req_d        = req_q | pedestrian_request;
    walk_d       = walk_q;
    walk_cnt_d   = walk_cnt_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;

    unique case (state_q)
      ST_ALL_RED: begin
        if (tmr_done) begin
          started_d = 1'b1;
          tmr_load  = 1'b1;
          if (emergency) begin
            state_d  = ST_PREEMPT;
            active_d = emergency_phase;
          end else begin
            state_d      = ST_GREEN;
            active_d     = next_phase;
            tmr_load_val = CNT_W'(GREEN_CYCLES - 1);
            // Entering green serves the latch plus any request this cycle.
            walk_d             = req_q[next_phase] | pedestrian_request[next_phase];
            req_d[next_phase]  = 1'b0;
            walk_cnt_d         = CNT_W'(WALK_CYCLES - 1);
          end
        end
      end
      ST_GREEN: begin
        if (walk_q) begin
          if (walk_cnt_q == '0) walk_d = 1'b0;
          else                  walk_cnt_d = walk_cnt_q - CNT_W'(1);
        end
        // Emergency aborts green at once; yellow/all-red are still served.
        if (emergency || tmr_done) begin
          state_d      = ST_YELLOW;
          tmr_load     = 1'b1;
          tmr_load_val = CNT_W'(YELLOW_CYCLES - 1);
          walk_d       = 1'b0;
        end
      end
      ST_YELLOW: begin
        if (tmr_done) begin
          state_d      = ST_ALL_RED;
          tmr_load     = 1'b1;
          tmr_load_val = CNT_W'(ALL_RED_CYCLES - 1);
        end
      end
      ST_PREEMPT: begin
        walk_d = 1'b0;
        if (!emergency) begin
          state_d      = ST_YELLOW;
          tmr_load     = 1'b1;
          tmr_load_val = CNT_W'(YELLOW_CYCLES - 1);
        end
      end
      default: state_d = ST_ALL_RED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ALL_RED;
      active_q   <= '0;
      started_q  <= 1'b0;
      req_q      <= '0;
      walk_q     <= 1'b0;
      walk_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      started_q  <= started_d;
      req_q      <= req_d;
      walk_q     <= walk_d;
      walk_cnt_q <= walk_cnt_d;
    end
  end

  assign active_oh = NUM_PHASES'(1) << active_q;

  always_comb begin
    for (int i = 0; i < NUM_PHASES; i++) begin
      lamp[i] = LAMP_RED;
      if (active_oh[i]) begin
        if (state_q == ST_GREEN || state_q == ST_PREEMPT) lamp[i] = LAMP_GREEN;
        else if (state_q == ST_YELLOW)                    lamp[i] = LAMP_YELLOW;
      end
      traffic_red[i]    = (lamp[i] == LAMP_RED);
      traffic_yellow[i] = (lamp[i] == LAMP_YELLOW);
      traffic_green[i]  = (lamp[i] == LAMP_GREEN);
    end
  end

  assign pedestrian_walk      = (walk_q && state_q == ST_GREEN) ? active_oh : '0;
  assign pedestrian_dont_walk = ~pedestrian_walk;
  assign active_phase         = active_q;
  assign preempt_active       = (state_q == ST_PREEMPT);
  assign state_o              = state_q;

endmodule

// File: tb/tb_intersection_controller.sv
// tb_intersection_controller
//   Directed scenarios for intersection_controller with NUM_PHASES=3,
//   GREEN=8, YELLOW=3, ALL_RED=2, WALK=5. Cycle 0 is the cycle in which
//   reset is released; inputs are driven and outputs sampled on the falling
//   edge, so inputs set at cycle c are sampled at the end of cycle c.
module tb_intersection_controller;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] pedestrian_request = '0;
  logic       emergency = 1'b0;
  logic [1:0] emergency_phase = '0;
  logic [2:0] traffic_red, traffic_yellow, traffic_green;
  logic [2:0] pedestrian_walk, pedestrian_dont_walk;
  logic [1:0] active_phase;
  logic       preempt_active;
  ctrl_state_e dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0] eg, ey, ew;
  logic [1:0] ea;
  logic       ep;

  intersection_controller #(
    .NUM_PHASES     (3),
    .GREEN_CYCLES   (8),
    .YELLOW_CYCLES  (3),
    .ALL_RED_CYCLES (2),
    .WALK_CYCLES    (5),
    .CNT_W          (8)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .pedestrian_request   (pedestrian_request),
    .emergency            (emergency),
    .emergency_phase      (emergency_phase),
    .traffic_red          (traffic_red),
    .traffic_yellow       (traffic_yellow),
    .traffic_green        (traffic_green),
    .pedestrian_walk      (pedestrian_walk),
    .pedestrian_dont_walk (pedestrian_dont_walk),
    .active_phase         (active_phase),
    .preempt_active       (preempt_active),
    .state_o              (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n              = 1'b0;
    emergency          = 1'b0;
    emergency_phase    = '0;
    pedestrian_request = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Expected lamps for a normal rotation; k = cycles since a green of p0 began.
  function automatic void rot(input int k, input int p0,
                              output logic [2:0] g, output logic [2:0] y,
                              output logic [1:0] a);
    int m;
    int p;
    m = k % 13;
    p = (p0 + k / 13) % 3;
    g = '0;
    y = '0;
    if (m < 8)       g = 3'b001 << p;
    else if (m < 11) y = 3'b001 << p;
    a = 2'(p);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    emergency = 1'b1;
    emergency_phase = 2'd2;
    pedestrian_request = 3'b111;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({traffic_red, traffic_yellow, traffic_green} !== {3'b111, 3'b000, 3'b000}) begin
      n_errors++;
      $display("FAIL reset lamps: got r=%b y=%b g=%b, expected r=111 y=000 g=000",
               traffic_red, traffic_yellow, traffic_green);
    end
    n_checks++;
    if (pedestrian_walk !== 3'b000 || pedestrian_dont_walk !== 3'b111) begin
      n_errors++;
      $display("FAIL reset walk: got walk=%b dont=%b, expected 000/111",
               pedestrian_walk, pedestrian_dont_walk);
    end
    n_checks++;
    if (active_phase !== 2'd0 || preempt_active !== 1'b0 || dbg_state !== ST_ALL_RED) begin
      n_errors++;
      $display("FAIL reset state: got active=%0d preempt=%b state=%0d, expected 0 0 %0d",
               active_phase, preempt_active, dbg_state, ST_ALL_RED);
    end
  endtask

  task automatic test_rotation();
    do_reset();
    for (int c = 0; c <= 45; c++) begin
      if (c < 2) begin eg = '0; ey = '0; ea = '0; end
      else rot(c - 2, 0, eg, ey, ea);
      ew = '0;
      ep = 1'b0;
      n_checks++;
      if ({traffic_red, traffic_yellow, traffic_green} !== {~(eg | ey), ey, eg}) begin
        n_errors++;
        $display("FAIL rotation lamps c=%0d: got r=%b y=%b g=%b, expected y=%b g=%b",
                 c, traffic_red, traffic_yellow, traffic_green, ey, eg);
      end
      n_checks++;
      if (active_phase !== ea || preempt_active !== ep || pedestrian_walk !== ew) begin
        n_errors++;
        $display("FAIL rotation status c=%0d: got active=%0d pre=%b walk=%b, expected %0d %b %b",
                 c, active_phase, preempt_active, pedestrian_walk, ea, ep, ew);
      end
      @(negedge clk);
    end
  endtask

  // Request for another phase, and request for the phase currently green.
  task automatic test_ped(input int req_cyc, input logic [2:0] req_bits,
                          input int walk_lo, input int walk_hi);
    do_reset();
    for (int c = 0; c <= 62; c++) begin
      pedestrian_request = (c == req_cyc) ? req_bits : 3'b000;
      if (c < 2) begin eg = '0; ey = '0; ea = '0; end
      else rot(c - 2, 0, eg, ey, ea);
      ew = (c >= walk_lo && c <= walk_hi) ? req_bits : 3'b000;
      n_checks++;
      if ({traffic_red, traffic_yellow, traffic_green} !== {~(eg | ey), ey, eg}) begin
        n_errors++;
        $display("FAIL ped lamps c=%0d: got r=%b y=%b g=%b, expected y=%b g=%b",
                 c, traffic_red, traffic_yellow, traffic_green, ey, eg);
      end
      n_checks++;
      if (pedestrian_walk !== ew || pedestrian_dont_walk !== ~ew) begin
        n_errors++;
        $display("FAIL ped walk c=%0d: got walk=%b dont=%b, expected walk=%b",
                 c, pedestrian_walk, pedestrian_dont_walk, ew);
      end
      @(negedge clk);
    end
    pedestrian_request = '0;
  endtask

  task automatic test_preempt();
    do_reset();
    for (int c = 0; c <= 57; c++) begin
      emergency          = (c >= 4 && c <= 19);
      emergency_phase    = (c < 12) ? 2'd2 : 2'd1;
      pedestrian_request = (c == 3) ? 3'b100 : 3'b000;
      eg = '0; ey = '0; ea = '0; ep = 1'b0; ew = '0;
      if (c >= 2 && c <= 4)        eg = 3'b001;
      else if (c >= 5 && c <= 7)   ey = 3'b001;
      else if (c >= 10 && c <= 20) begin eg = 3'b100; ea = 2'd2; ep = 1'b1; end
      else if (c >= 21 && c <= 23) begin ey = 3'b100; ea = 2'd2; end
      else if (c >= 24 && c <= 25) ea = 2'd2;
      else if (c >= 26)            rot(c - 26, 0, eg, ey, ea);
      if (c >= 52 && c <= 56) ew = 3'b100;
      n_checks++;
      if ({traffic_red, traffic_yellow, traffic_green} !== {~(eg | ey), ey, eg}) begin
        n_errors++;
        $display("FAIL preempt lamps c=%0d: got r=%b y=%b g=%b, expected y=%b g=%b",
                 c, traffic_red, traffic_yellow, traffic_green, ey, eg);
      end
      n_checks++;
      if (active_phase !== ea || preempt_active !== ep || pedestrian_walk !== ew) begin
        n_errors++;
        $display("FAIL preempt status c=%0d: got active=%0d pre=%b walk=%b, expected %0d %b %b",
                 c, active_phase, preempt_active, pedestrian_walk, ea, ep, ew);
      end
      @(negedge clk);
    end
    emergency = 1'b0;
  endtask

  // Short emergency pulse aborts phase 0 green (and its walk), no preemption.
  task automatic test_emergency_pulse();
    do_reset();
    for (int c = 0; c <= 44; c++) begin
      emergency          = (c >= 4 && c <= 6);
      emergency_phase    = 2'd2;
      pedestrian_request = (c == 0) ? 3'b001 : 3'b000;
      eg = '0; ey = '0; ea = '0; ep = 1'b0; ew = '0;
      if (c >= 2 && c <= 4)       begin eg = 3'b001; ew = 3'b001; end
      else if (c >= 5 && c <= 7)  ey = 3'b001;
      else if (c >= 10)           rot(c - 10, 1, eg, ey, ea);
      n_checks++;
      if ({traffic_red, traffic_yellow, traffic_green} !== {~(eg | ey), ey, eg}) begin
        n_errors++;
        $display("FAIL pulse lamps c=%0d: got r=%b y=%b g=%b, expected y=%b g=%b",
                 c, traffic_red, traffic_yellow, traffic_green, ey, eg);
      end
      n_checks++;
      if (active_phase !== ea || preempt_active !== ep || pedestrian_walk !== ew) begin
        n_errors++;
        $display("FAIL pulse status c=%0d: got active=%0d pre=%b walk=%b, expected %0d %b %b",
                 c, active_phase, preempt_active, pedestrian_walk, ea, ep, ew);
      end
      @(negedge clk);
    end
    emergency = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      emergency          = 1'b1;
      emergency_phase    = 2'd1;
      pedestrian_request = (c == 3) ? 3'b111 : 3'b000;
      eg = (c >= 2) ? 3'b010 : 3'b000;
      ea = (c >= 2) ? 2'd1 : 2'd0;
      ep = (c >= 2);
      n_checks++;
      if (traffic_green !== eg || active_phase !== ea || preempt_active !== ep ||
          pedestrian_walk !== 3'b000) begin
        n_errors++;
        $display("FAIL areset pre c=%0d: got g=%b active=%0d pre=%b walk=%b, expected g=%b %0d %b 000",
                 c, traffic_green, active_phase, preempt_active, pedestrian_walk, eg, ea, ep);
      end
      @(negedge clk);
    end
    // Assert reset between clock edges; outputs must clear without a clock.
    rst_n = 1'b0;
    emergency = 1'b0;
    pedestrian_request = '0;
    #1;
    n_checks++;
    if ({traffic_red, traffic_yellow, traffic_green} !== {3'b111, 3'b000, 3'b000} ||
        pedestrian_dont_walk !== 3'b111 || preempt_active !== 1'b0 || active_phase !== 2'd0) begin
      n_errors++;
      $display("FAIL areset immediate: got r=%b y=%b g=%b dont=%b pre=%b active=%0d, expected 111 000 000 111 0 0",
               traffic_red, traffic_yellow, traffic_green, pedestrian_dont_walk,
               preempt_active, active_phase);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c <= 30; c++) begin
      if (c < 2) begin eg = '0; ey = '0; ea = '0; end
      else rot(c - 2, 0, eg, ey, ea);
      n_checks++;
      if ({traffic_red, traffic_yellow, traffic_green} !== {~(eg | ey), ey, eg} ||
          active_phase !== ea || pedestrian_walk !== 3'b000 || preempt_active !== 1'b0) begin
        n_errors++;
        $display("FAIL areset restart c=%0d: got r=%b y=%b g=%b active=%0d walk=%b pre=%b, expected y=%b g=%b active=%0d",
                 c, traffic_red, traffic_yellow, traffic_green, active_phase,
                 pedestrian_walk, preempt_active, ey, eg, ea);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_ped(3, 3'b010, 15, 19);
    test_ped(5, 3'b001, 41, 45);
    test_preempt();
    test_emergency_pulse();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
